// File: rtl/alu_pkg.sv
// alu_seq shared definitions: opcodes, FSM states, flag bundle.
// Imported by alu_core and alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef struct packed {
    logic zero;
    logic cout;
    logic overflow;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops (no MUL).
// Ports: a_i, b_i, op_i in; res_o, cout_o, ovf_o, err_o out.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;
  logic           slt;

  assign add_s = {1'b0, a_i} + {1'b0, b_i};
  assign sub_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  // Direct signed compare: immune to subtract overflow.
  assign slt   = $signed(a_i) < $signed(b_i);

  always_comb begin
    res_o  = '0;
    cout_o = 1'b0;
    ovf_o  = 1'b0;
    err_o  = 1'b0;
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_NAND: res_o = ~(a_i & b_i);
      OP_ADD: begin
        res_o  = add_s[M:0];
        cout_o = add_s[WIDTH];
        ovf_o  = (a_i[M] == b_i[M]) &&
                 (add_s[M] != a_i[M]);
      end
      OP_SUB: begin
        res_o  = sub_s[M:0];
        cout_o = sub_s[WIDTH];
        ovf_o  = (a_i[M] != b_i[M]) &&
                 (sub_s[M] != a_i[M]);
      end
      OP_SLT:  res_o = {{(WIDTH-1){1'b0}}, slt};
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with iterative shift-add MUL.
// In: clk, rst, in_valid, src1, src2, ALU_control, out_ready.
// Out: in_ready, out_valid, result, zero, cout, overflow, err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  res_q, res_d;
  flags_t            flg_q, flg_d;

  logic [WIDTH-1:0]  c_res;
  logic              c_cout;
  logic              c_ovf;
  logic              c_err;
  logic [W2-1:0]     acc_nx;
  logic              accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (src1),
    .b_i   (src2),
    .op_i  (ALU_control),
    .res_o (c_res),
    .cout_o(c_cout),
    .ovf_o (c_ovf),
    .err_o (c_err)
  );

  assign in_ready = (state_q == S_IDLE) &&
                    (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Accumulator after the current multiplier bit.
  assign acc_nx = acc_q +
                  (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    vld_d    = vld_q;
    res_d    = res_q;
    flg_d    = flg_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALU_control == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, src1};
            mplier_d = src2;
          end else begin
            vld_d          = 1'b1;
            res_d          = c_res;
            flg_d.zero     = (c_res == '0);
            flg_d.cout     = c_cout;
            flg_d.overflow = c_ovf;
            flg_d.err      = c_err;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d        = S_IDLE;
          vld_d          = 1'b1;
          res_d          = acc_nx[WIDTH-1:0];
          flg_d.zero     = (acc_nx[WIDTH-1:0] == '0);
          flg_d.cout     = 1'b0;
          flg_d.overflow = |acc_nx[W2-1:WIDTH];
          flg_d.err      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      vld_q    <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = flg_q.zero;
  assign cout      = flg_q.cout;
  assign overflow  = flg_q.overflow;
  assign err       = flg_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH = 32).
// Table-driven single-cycle ops plus MUL/stream/reset sequences.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1, src2;
  logic [3:0]   ALU_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, cout, overflow, err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .ALU_control(ALU_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .cout       (cout),
    .overflow   (overflow),
    .err        (err)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    logic         e;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid    = 1'b1;
    ALU_control = op;
    src1        = a;
    src2        = b;
  endtask

  task automatic run_mul(input string nm,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] er,
                         input logic ez,
                         input logic eo);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 0;
    out_ready = 1'b1;
    drive(4'b1000, a, b);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1;
      tick();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd32);
    chk({nm, "_busy_ready"}, 64'(rdy_seen), 64'd0);
    chk({nm, "_res"}, 64'(result), 64'(er));
    chk({nm, "_zero"}, 64'(zero), 64'(ez));
    chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
    chk({nm, "_cout"}, 64'(cout), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
    tick();
  endtask

  initial begin
    logic [W-1:0] held;
    bit           bad;

    vecs[0]  = '{"add_ovf", 4'b0010, 32'h7FFFFFFF,
                 32'h1, 32'h80000000, 0, 0, 1, 0};
    vecs[1]  = '{"add_wrap", 4'b0010, 32'hFFFFFFFF,
                 32'h1, 32'h0, 1, 1, 0, 0};
    vecs[2]  = '{"sub_eq", 4'b0110, 32'd5,
                 32'd5, 32'h0, 1, 1, 0, 0};
    vecs[3]  = '{"sub_borrow", 4'b0110, 32'd3,
                 32'd5, 32'hFFFFFFFE, 0, 0, 0, 0};
    vecs[4]  = '{"sub_ovf", 4'b0110, 32'h80000000,
                 32'h1, 32'h7FFFFFFF, 0, 1, 1, 0};
    vecs[5]  = '{"slt_neg", 4'b0111, 32'h80000000,
                 32'h1, 32'h1, 0, 0, 0, 0};
    vecs[6]  = '{"slt_pos", 4'b0111, 32'h7FFFFFFF,
                 32'h80000000, 32'h0, 1, 0, 0, 0};
    vecs[7]  = '{"and", 4'b0000, 32'hF0F0F0F0,
                 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0};
    vecs[8]  = '{"or", 4'b0001, 32'hF0F0F0F0,
                 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 0};
    vecs[9]  = '{"nor", 4'b1100, 32'h0,
                 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0};
    vecs[10] = '{"nand", 4'b1101, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0};
    vecs[11] = '{"illegal", 4'b1111, 32'h1234,
                 32'h5678, 32'h0, 1, 0, 0, 1};
    vecs[12] = '{"err_clr", 4'b0010, 32'd1,
                 32'd2, 32'd3, 0, 0, 0, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    src1 = '0;
    src2 = '0;
    ALU_control = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, cout, overflow, err}),
        64'd0);

    // Table: back-to-back, one result per cycle.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_rdy"}, 64'(in_ready), 64'd1);
      tick();
      chk({vecs[i].name, "_vld"}, 64'(out_valid), 64'd1);
      chk({vecs[i].name, "_res"}, 64'(result),
          64'(vecs[i].res));
      chk({vecs[i].name, "_flags"},
          64'({zero, cout, overflow, err}),
          64'({vecs[i].z, vecs[i].c, vecs[i].o,
               vecs[i].e}));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_vld", 64'(out_valid), 64'd0);

    run_mul("mul_big", 32'h00010000, 32'h00010000,
            32'h0, 1'b1, 1'b1);
    run_mul("mul_1234", 32'd1234, 32'd5678,
            32'd7006652, 1'b0, 1'b0);

    // Streaming then backpressure.
    out_ready = 1'b1;
    drive(4'b0000, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("st_and", 64'(result), 64'h0F000F00);
    drive(4'b0001, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("st_or", 64'(result), 64'hFF0FFF0F);
    drive(4'b1100, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("st_nor", 64'(result), 64'h00F000F0);
    drive(4'b1101, 32'hFF00FF00, 32'h0F0F0F0F);
    tick();
    chk("st_nand", 64'(result), 64'hF0FFF0FF);
    chk("st_nand_vld", 64'(out_valid), 64'd1);
    held = result;
    out_ready = 1'b0;
    drive(4'b0010, 32'd10, 32'd20);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (in_ready) bad = 1;
      tick();
      if (!out_valid || result !== held) bad = 1;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(in_ready), 64'd1);
    tick();
    chk("bp_next_res", 64'(result), 64'd30);
    chk("bp_next_vld", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();

    // Reset in the middle of a multiply.
    drive(4'b1000, 32'd7, 32'd9);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) bad = 1;
    end
    chk("mrst_no_result", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
